// File: rtl/lb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : lb_uart_tx_buffer
//  Purpose  : Byte FIFO plus launch sequencer that sits in front of the UART
//             Tx control unit. PicoBlaze output-port writes are queued here.
//             Each byte is presented on tx_data_o with a one-cycle tx_start_o
//             pulse. The next byte is not launched until the Tx unit returns
//             tx_done_i. Full/empty/level/overflow status is provided for
//             PicoBlaze input-port reads.
//  Ports    : clk_i        system clock, rising edge
//             reset_ni     asynchronous active-low reset
//             cs_i         block enable; gates only IDLE->LAUNCH
//             wr_i         write strobe, one byte per cycle
//             data_in_i    byte to enqueue
//             clr_ovf_i    clears the sticky overflow flag
//             tx_done_i    end-of-frame pulse from the Tx control unit
//             tx_start_o   one-cycle frame launch pulse
//             tx_data_o    byte in flight, held until the next launch
//             full_o       level_o == 2**DEPTH_LOG2
//             empty_o      level_o == 0
//             level_o      queued entries, excluding the byte in flight
//             overflow_o   sticky: a write was dropped
//             busy_o       a frame is in flight
//  Options  : LB_UART_TX_PARITY_GEN_EN adds bit8_i, parity_odd_i and
//             tx_parity_o; the parity bit is captured together with tx_data_o.
//  Revision : 1.0  initial release
// ============================================================================
module lb_uart_tx_buffer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
`ifdef LB_UART_TX_PARITY_GEN_EN
    input  logic                  bit8_i,
    input  logic                  parity_odd_i,
    output logic                  tx_parity_o,
`endif
    input  logic                  cs_i,
    input  logic                  wr_i,
    input  logic [DATA_W-1:0]     data_in_i,
    input  logic                  clr_ovf_i,
    input  logic                  tx_done_i,
    output logic                  tx_start_o,
    output logic [DATA_W-1:0]     tx_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_W-1:0]       tx_data_q, tx_data_d;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // A pop frees a slot in the same cycle, so a write at full is still
    // accepted when it coincides with a launch.
    assign w_pop  = (state_q == S_IDLE) && cs_i && !empty_q;
    assign w_push = wr_i && (!full_q || w_pop);
    assign w_drop = wr_i && full_q && !w_pop;

    // FSM next state and decoded outputs
    always_comb begin
        state_d    = state_q;
        tx_start_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start_o = 1'b1;
                busy_o     = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                busy_o = 1'b1;
                if (tx_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping next state
    always_comb begin
        wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d     = (level_d == c_DEPTH);
        empty_d    = (level_d == '0);
        overflow_d = w_drop ? 1'b1 : (clr_ovf_i ? 1'b0 : overflow_q);
        tx_data_d  = w_pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage array carries no reset; contents are meaningless once the
    // pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_in_i;
        end
    end

`ifdef LB_UART_TX_PARITY_GEN_EN
    logic                    tx_parity_q, tx_parity_d;
    logic [DATA_W-1:0]       w_head;

    assign w_head = mem_q[rd_ptr_q];

    // Parity covers 8 or 7 data bits; odd parity is the inverted even XOR.
    always_comb begin
        tx_parity_d = tx_parity_q;
        if (w_pop) begin
            tx_parity_d = (bit8_i ? ^w_head[7:0] : ^w_head[6:0]) ^ parity_odd_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_parity_q <= 1'b0;
        end else begin
            tx_parity_q <= tx_parity_d;
        end
    end

    assign tx_parity_o = tx_parity_q;
`endif

    assign tx_data_o  = tx_data_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire
